// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, ALU-op legalisation and optional
// operand forwarding (enabled by defining ID_EX_FORWARD_EN).
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] rs_data1,
    input  logic [31:0] rs_data2,
    input  logic [31:0] imm,
    input  logic        alu_src,
    input  logic [3:0]  alu_op_in,
    input  logic        reg_write_in,
    input  logic        flush,
    input  logic [4:0]  exmem_rd,
    input  logic [4:0]  memwb_rd,
    input  logic        exmem_we,
    input  logic        memwb_we,
    input  logic [31:0] exmem_result,
    input  logic [31:0] memwb_result,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [3:0]  ALUOp,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic [31:0] store_data,
    output logic        illegal_op
);

    logic        valid_q, valid_d;
    logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [31:0] rs_data1_q, rs_data1_d, rs_data2_q, rs_data2_d, imm_q, imm_d;
    logic        alu_src_q, alu_src_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic        reg_write_q, reg_write_d;
    logic        illegal_q, illegal_d;

    logic        load;
    logic        op_legal;
    logic [31:0] fwd_a, fwd_b;

    assign in_ready = ~valid_q | out_ready;
    assign load     = in_valid & in_ready & ~flush;

    always_comb begin
        case (alu_op_in)
            4'b0000, 4'b0001, 4'b0010, 4'b0110: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    end

    always_comb begin
        valid_d     = valid_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        rs_data1_d  = rs_data1_q;
        rs_data2_d  = rs_data2_q;
        imm_d       = imm_q;
        alu_src_d   = alu_src_q;
        alu_op_d    = alu_op_q;
        reg_write_d = reg_write_q;
        illegal_d   = illegal_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d     = 1'b1;
            rs1_d       = rs1;
            rs2_d       = rs2;
            rd_d        = rd;
            rs_data1_d  = rs_data1;
            rs_data2_d  = rs_data2;
            imm_d       = imm;
            alu_src_d   = alu_src;
            // Unsupported ops degrade to a harmless AND that never writes back.
            alu_op_d    = op_legal ? alu_op_in : 4'b0000;
            reg_write_d = reg_write_in & op_legal;
            illegal_d   = ~op_legal;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
            rs_data1_q  <= 32'd0;
            rs_data2_q  <= 32'd0;
            imm_q       <= 32'd0;
            alu_src_q   <= 1'b0;
            alu_op_q    <= 4'd0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            rs_data1_q  <= rs_data1_d;
            rs_data2_q  <= rs_data2_d;
            imm_q       <= imm_d;
            alu_src_q   <= alu_src_d;
            alu_op_q    <= alu_op_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
        end
    end

`ifdef ID_EX_FORWARD_EN
    // Forwarding is re-evaluated every cycle so a stalled bundle picks up late results.
    always_comb begin
        fwd_a = rs_data1_q;
        fwd_b = rs_data2_q;
        if (exmem_we && exmem_rd == rs1_q && rs1_q != 5'd0) begin
            fwd_a = exmem_result;
        end else if (memwb_we && memwb_rd == rs1_q && rs1_q != 5'd0) begin
            fwd_a = memwb_result;
        end
        if (exmem_we && exmem_rd == rs2_q && rs2_q != 5'd0) begin
            fwd_b = exmem_result;
        end else if (memwb_we && memwb_rd == rs2_q && rs2_q != 5'd0) begin
            fwd_b = memwb_result;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{exmem_rd, memwb_rd, exmem_we, memwb_we, exmem_result, memwb_result,
                          rs1_q, rs2_q};
    always_comb begin
        fwd_a = rs_data1_q;
        fwd_b = rs_data2_q;
    end
`endif

    assign out_valid     = valid_q;
    assign A             = fwd_a;
    assign store_data    = fwd_b;
    assign B             = alu_src_q ? imm_q : fwd_b;
    assign ALUOp         = alu_op_q;
    assign rd_out        = rd_q;
    assign reg_write_out = valid_q & reg_write_q;
    assign illegal_op    = valid_q & illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; expectations follow ID_EX_FORWARD_EN if defined.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, alu_src, reg_write_in, flush;
    logic [4:0]  rs1, rs2, rd, exmem_rd, memwb_rd, rd_out;
    logic [31:0] rs_data1, rs_data2, imm, exmem_result, memwb_result;
    logic        exmem_we, memwb_we, out_ready, out_valid, reg_write_out, illegal_op;
    logic [3:0]  alu_op_in, ALUOp;
    logic [31:0] A, B, store_data;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        src;
        logic [3:0]  op;
        logic        rw;
    } ent_t;

    typedef struct {
        logic [31:0] a, b, sd;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        rw, ill;
    } exp_t;

    ent_t sb[$];
    logic m_valid = 1'b0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .rs_data1(rs_data1), .rs_data2(rs_data2),
        .imm(imm), .alu_src(alu_src), .alu_op_in(alu_op_in), .reg_write_in(reg_write_in),
        .flush(flush), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_we(exmem_we),
        .memwb_we(memwb_we), .exmem_result(exmem_result), .memwb_result(memwb_result),
        .out_ready(out_ready), .out_valid(out_valid), .A(A), .B(B), .ALUOp(ALUOp),
        .rd_out(rd_out), .reg_write_out(reg_write_out), .store_data(store_data),
        .illegal_op(illegal_op)
    );

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] data);
`ifdef ID_EX_FORWARD_EN
        if (exmem_we && exmem_rd == idx && idx != 5'd0) return exmem_result;
        if (memwb_we && memwb_rd == idx && idx != 5'd0) return memwb_result;
`endif
        return data;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        ent_t s;
        logic legal;
        s = sb[0];
        legal = (s.op == 4'b0000) || (s.op == 4'b0001) || (s.op == 4'b0010) ||
                (s.op == 4'b0110);
        e.a   = fwd(s.rs1, s.d1);
        e.sd  = fwd(s.rs2, s.d2);
        e.b   = s.src ? s.imm : e.sd;
        e.op  = legal ? s.op : 4'b0000;
        e.rd  = s.rd;
        e.rw  = s.rw & legal;
        e.ill = ~legal;
        return e;
    endfunction

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdi,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im,
                         input logic src, input logic [3:0] op, input logic rw);
        in_valid = 1'b1; rs1 = r1; rs2 = r2; rd = rdi; rs_data1 = d1; rs_data2 = d2;
        imm = im; alu_src = src; alu_op_in = op; reg_write_in = rw;
    endtask

    // Advance one clock and update the reference model from the inputs seen at the edge.
    task automatic step();
        logic ld;
        ent_t e;
        ld = in_valid && (!m_valid || out_ready) && !flush;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.d1 = rs_data1; e.d2 = rs_data2;
        e.imm = imm; e.src = alu_src; e.op = alu_op_in; e.rw = reg_write_in;
        @(posedge clk);
        #1;
        if (reset) begin
            m_valid = 1'b0;
            sb.delete();
        end else if (flush) begin
            m_valid = 1'b0;
            sb.delete();
        end else if (ld) begin
            if (sb.size() > 0) void'(sb.pop_front());
            sb.push_back(e);
            m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
            void'(sb.pop_front());
            m_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        drive(5'd1, 5'd2, 5'd3, 32'hdead, 32'hbeef, 32'h1, 1'b0, 4'b0010, 1'b1);
        step();
        step();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (A !== 32'd0) begin n_bad++; $display("FAIL reset_A got %h want 0", A); end
        n_cmp++; if (B !== 32'd0) begin n_bad++; $display("FAIL reset_B got %h want 0", B); end
        n_cmp++; if (ALUOp !== 4'd0) begin n_bad++; $display("FAIL reset_op got %h want 0", ALUOp); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", in_ready); end
        n_cmp++; if (store_data !== 32'd0) begin n_bad++; $display("FAIL reset_sd got %h want 0", store_data); end
        n_cmp++; if (reg_write_out !== 1'b0 || illegal_op !== 1'b0 || rd_out !== 5'd0) begin
            n_bad++; $display("FAIL reset_misc got rw=%b ill=%b rd=%0d want 0", reg_write_out, illegal_op, rd_out);
        end
    endtask

    task automatic test_basic_load();
        exp_t e;
        out_ready = 1'b1;
        drive(5'd4, 5'd6, 5'd9, 32'd5, 32'd7, 32'h99, 1'b0, 4'b0110, 1'b1);
        step();
        in_valid = 1'b0;
        #1;
        e = predict();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL load_valid got %b want 1", out_valid); end
        n_cmp++; if (A !== 32'd5 || A !== e.a) begin n_bad++; $display("FAIL load_A got %h want 5", A); end
        n_cmp++; if (B !== 32'd7 || B !== e.b) begin n_bad++; $display("FAIL load_B got %h want 7", B); end
        n_cmp++; if (ALUOp !== 4'b0110) begin n_bad++; $display("FAIL load_op got %b want 0110", ALUOp); end
        n_cmp++; if (rd_out !== e.rd || reg_write_out !== e.rw) begin
            n_bad++; $display("FAIL load_rd got %0d/%b want %0d/%b", rd_out, reg_write_out, e.rd, e.rw);
        end
        step();
        #1;
        n_cmp++; if (out_valid !== m_valid || reg_write_out !== 1'b0) begin
            n_bad++; $display("FAIL drain got v=%b rw=%b want v=%b rw=0", out_valid, reg_write_out, m_valid);
        end
    endtask

    task automatic test_hold();
        exp_t e;
        out_ready = 1'b0;
        drive(5'd1, 5'd2, 5'd10, 32'h1111, 32'h2222, 32'h3333, 1'b1, 4'b0000, 1'b1);
        step();
        drive(5'd5, 5'd6, 5'd11, 32'haaaa, 32'hbbbb, 32'hcccc, 1'b0, 4'b0001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            e = predict();
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready%0d got %b want 0", i, in_ready); end
            n_cmp++; if (A !== e.a || B !== e.b || ALUOp !== e.op || rd_out !== e.rd) begin
                n_bad++; $display("FAIL hold_data%0d got A=%h B=%h op=%b rd=%0d want A=%h B=%h op=%b rd=%0d",
                                  i, A, B, ALUOp, rd_out, e.a, e.b, e.op, e.rd);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        #1;
        e = predict();
        n_cmp++; if (out_valid !== 1'b1 || A !== 32'haaaa || B !== e.b || ALUOp !== 4'b0001) begin
            n_bad++; $display("FAIL release_new got v=%b A=%h B=%h op=%b want v=1 A=aaaa B=%h op=0001",
                              out_valid, A, B, ALUOp, e.b);
        end
        step();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [3:0] ops [4];
        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110;
        out_ready = 1'b1; exmem_we = 1'b0; memwb_we = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                drive(5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)),
                      $urandom, $urandom, $urandom, 1'(i % 2), ops[i], 1'b1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i > 0) begin
                e = predict();
                n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
                    n_bad++; $display("FAIL b2b_hs%0d got v=%b r=%b want 1/1", i, out_valid, in_ready);
                end
                n_cmp++; if (A !== e.a || B !== e.b || store_data !== e.sd || ALUOp !== e.op) begin
                    n_bad++; $display("FAIL b2b_data%0d got A=%h B=%h sd=%h op=%b want A=%h B=%h sd=%h op=%b",
                                      i, A, B, store_data, ALUOp, e.a, e.b, e.sd, e.op);
                end
            end
            step();
        end
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_forward();
        logic [31:0] want;
        out_ready = 1'b0;
        drive(5'd3, 5'd3, 5'd1, 32'h111, 32'h222, 32'h7, 1'b0, 4'b0010, 1'b1);
        step();
        in_valid = 1'b0;
        exmem_rd = 5'd3; exmem_result = 32'h10; exmem_we = 1'b1;
        memwb_rd = 5'd3; memwb_result = 32'h20; memwb_we = 1'b1;
        #1;
`ifdef ID_EX_FORWARD_EN
        want = 32'h10;
`else
        want = 32'h111;
`endif
        n_cmp++; if (A !== want) begin n_bad++; $display("FAIL fwd_both_A got %h want %h", A, want); end
        n_cmp++; if (store_data !== predict().sd || B !== predict().b) begin
            n_bad++; $display("FAIL fwd_both_B got B=%h sd=%h want %h", B, store_data, predict().sd);
        end
        exmem_we = 1'b0;
        #1;
`ifdef ID_EX_FORWARD_EN
        want = 32'h20;
`else
        want = 32'h111;
`endif
        n_cmp++; if (A !== want) begin n_bad++; $display("FAIL fwd_memwb_A got %h want %h", A, want); end
        exmem_we = 1'b1;
        out_ready = 1'b1;
        drive(5'd0, 5'd0, 5'd2, 32'h333, 32'h444, 32'h8, 1'b0, 4'b0010, 1'b1);
        exmem_rd = 5'd0; memwb_rd = 5'd0;
        step();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (A !== 32'h333 || store_data !== 32'h444) begin
            n_bad++; $display("FAIL fwd_zero got A=%h sd=%h want 333/444", A, store_data);
        end
        step();
        exmem_we = 1'b0; memwb_we = 1'b0;
    endtask

    task automatic test_illegal();
        exp_t e;
        out_ready = 1'b1;
        drive(5'd1, 5'd2, 5'd7, 32'h5, 32'h6, 32'h0, 1'b0, 4'b1111, 1'b1);
        step();
        drive(5'd1, 5'd2, 5'd8, 32'h5, 32'h6, 32'h0, 1'b0, 4'b0001, 1'b1);
        #1;
        n_cmp++; if (ALUOp !== 4'b0000 || illegal_op !== 1'b1 || reg_write_out !== 1'b0) begin
            n_bad++; $display("FAIL illegal got op=%b ill=%b rw=%b want 0000/1/0", ALUOp, illegal_op, reg_write_out);
        end
        step();
        in_valid = 1'b0;
        #1;
        e = predict();
        n_cmp++; if (ALUOp !== 4'b0001 || illegal_op !== 1'b0 || reg_write_out !== e.rw || rd_out !== 5'd8) begin
            n_bad++; $display("FAIL legal_after got op=%b ill=%b rw=%b rd=%0d want 0001/0/%b/8",
                              ALUOp, illegal_op, reg_write_out, rd_out, e.rw);
        end
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(5'd1, 5'd2, 5'd4, 32'h50, 32'h60, 32'h0, 1'b0, 4'b0010, 1'b1);
        step();
        flush = 1'b1;
        drive(5'd3, 5'd4, 5'd5, 32'h70, 32'h80, 32'h0, 1'b0, 4'b0010, 1'b1);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== m_valid || reg_write_out !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL flush got v=%b rw=%b r=%b want 0/0/1", out_valid, reg_write_out, in_ready);
        end
        step();
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_nocap got %b want 0", out_valid); end
        drive(5'd1, 5'd2, 5'd4, 32'h90, 32'ha0, 32'h0, 1'b0, 4'b0010, 1'b1);
        step();
        reset = 1'b1; flush = 1'b1;
        drive(5'd3, 5'd4, 5'd5, 32'hb0, 32'hc0, 32'h0, 1'b0, 4'b0010, 1'b1);
        step();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || A !== 32'd0 || B !== 32'd0 || store_data !== 32'd0) begin
            n_bad++; $display("FAIL reset_mid got v=%b A=%h B=%h sd=%h want all 0", out_valid, A, B, store_data);
        end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0; rs_data1 = '0; rs_data2 = '0; imm = '0;
        alu_src = 1'b0; alu_op_in = '0; reg_write_in = 1'b0;
        exmem_rd = '0; memwb_rd = '0; exmem_we = 1'b0; memwb_we = 1'b0;
        exmem_result = '0; memwb_result = '0;
        test_reset();
        test_basic_load();
        test_hold();
        test_back_to_back();
        test_forward();
        test_illegal();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Port clk  in  1  single clock; all state updates on rising edge.
REQ-002 Port reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 Port in_valid  in  1  upstream decode bundle valid.
REQ-004 Port in_ready  out  1  stage can accept a bundle this cycle.
REQ-005 Port rs1, rs2, rd  in  5 each  source/destination register indices.
REQ-006 Port rs_data1, rs_data2  in  32 each  register-file read data.
REQ-007 Port imm  in  32  sign-extended immediate.
REQ-008 Port alu_src  in  1  1 = B from imm, 0 = B from rs2 path.
REQ-009 Port alu_op_in  in  4  requested ALU operation.
REQ-010 Port reg_write_in  in  1  instruction writes rd.
REQ-011 Port flush  in  1  kill held and incoming bundle.
REQ-012 Port exmem_rd, memwb_rd  in  5 each  forwarding destination indices.
REQ-013 Port exmem_we, memwb_we  in  1 each  forwarding write enables.
REQ-014 Port exmem_result, memwb_result  in  32 each  forwarding data.
REQ-015 Port out_ready  in  1  ALU/EX consumer accepts bundle.
REQ-016 Port out_valid  out  1  A/B/ALUOp hold a live bundle.
REQ-017 Port A, B  out  32 each  ALU operands.
REQ-018 Port ALUOp  out  4  ALU operation code.
REQ-019 Port rd_out  out  5; reg_write_out  out  1  destination passthrough.
REQ-020 Port store_data  out  32  forwarded rs2 value (independent of alu_src).
REQ-021 Port illegal_op  out  1  held bundle carried an unsupported op.

Function
REQ-022 Legal ALUOp codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB; all others unsupported.
REQ-023 Single-entry pipeline register; in_ready = ~out_valid | out_ready (combinational).
REQ-024 Load when in_valid & in_ready & ~flush: capture all inputs; out_valid=1 next cycle; latency 1 cycle.
REQ-025 out_ready & out_valid & no load: out_valid=0 next cycle.
REQ-026 out_valid & ~out_ready: every held field stable; in_ready=0.
REQ-027 Simultaneous drain and load: new bundle replaces old in one cycle, out_valid stays 1 (full throughput).
REQ-028 flush: out_valid=0 next cycle, incoming bundle discarded; flush beats load and hold.
REQ-029 Unsupported alu_op_in: latch ALUOp=0000, reg_write_out=0, illegal_op=1 for that bundle.
REQ-030 reg_write_out is 0 whenever out_valid=0.
REQ-031 Forwarding (held rsN, combinational each cycle while held): exmem_we & exmem_rd==rsN & rsN!=0 -> exmem_result; else memwb_we & memwb_rd==rsN & rsN!=0 -> memwb_result; else latched rs_dataN.
REQ-032 EX/MEM beats MEM/WB when both match; index 0 always yields latched data.
REQ-033 A = fwd(rs1); store_data = fwd(rs2); B = alu_src ? imm : fwd(rs2).

Reset
REQ-034 reset: out_valid=0, all held fields 0, so A=0, B=0, ALUOp=0000, rd_out=0, reg_write_out=0, illegal_op=0, store_data=0 next cycle.
REQ-035 reset mid-hold or concurrent with load/flush discards everything; reset has highest priority.

Configuration
REQ-036 Macro ID_EX_FORWARD_EN defined: REQ-031/032 forwarding active.
REQ-037 Macro undefined: A=latched rs_data1, store_data=latched rs_data2, B=alu_src?imm:rs_data2; forwarding inputs ignored; handshake unchanged.

Verification
REQ-038 reset 1 cycle -> out_valid=0, A=B=0, ALUOp=0000, in_ready=1.
REQ-039 Load rs_data1=5, rs_data2=7, alu_op_in=0110, alu_src=0, out_ready=1 -> next cycle out_valid=1, A=5, B=7, ALUOp=0110.
REQ-040 Hold out_ready=0 three cycles with in_valid=1 new data -> in_ready=0, outputs unchanged; release -> new bundle next cycle.
REQ-041 rs1=3, exmem rd=3 result=0x10, memwb rd=3 result=0x20 (both we=1) -> A=0x10; rs1=0 same stimulus -> A=latched data.
REQ-042 alu_op_in=1111, reg_write_in=1 -> ALUOp=0000, illegal_op=1, reg_write_out=0.
REQ-043 flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, no bundle captured.
